dsi_pattern_gen: RTL and testbench

- Dual-pixel (PixelPerClock = 2) test-pattern source for the DSI TX path.
- Sits between vga_gen and dsi_tx. Consumes vga_gen timing (hs/vs/de/valid/x/y) and produces 48-bit packed pixel data with the timing aligned to it.
- Also produces the frame counter and the pixel-domain release reset (o_video_rstn) for dsi_tx reset_pixel_n.
- Runs entirely in the pixel clock domain (sysclk_div_2).

---
 rtl/dsi_pattern_gen_if.sv | 32 +++
 rtl/dsi_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_dsi_pattern_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dsi_pattern_gen_if.sv
// Timing, control and pixel signals between the timing source, the pattern
// generator and the DSI TX. The master drives the inputs and the slave drives the outputs.
interface dsi_pattern_gen_if;
  logic        i_hs;
  logic        i_vs;
  logic        i_de;
  logic        i_valid;
  logic [11:0] i_x;
  logic [11:0] i_y;
  logic [2:0]  i_mode;
  logic        i_mode_auto;

  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic        o_valid;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic [47:0] o_data;
  logic [8:0]  o_frame_cnt;
  logic        o_video_rstn;

  modport master (
    output i_hs, i_vs, i_de, i_valid, i_x, i_y, i_mode, i_mode_auto,
    input  o_hs, o_vs, o_de, o_valid, o_x, o_y, o_data, o_frame_cnt, o_video_rstn
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_valid, i_x, i_y, i_mode, i_mode_auto,
    output o_hs, o_vs, o_de, o_valid, o_x, o_y, o_data, o_frame_cnt, o_video_rstn
  );
endinterface

// File: rtl/dsi_pattern_gen.sv
// Dual-pixel test-pattern source. It uses a two-stage pipeline that aligns the timing with the 48-bit pixel pair.
// It also provides the frame counter and the hsync-counted reset release for the DSI TX.
module dsi_pattern_gen #(
  parameter int MAX_HRES        = 1080,
  parameter int MAX_VRES        = 1920,
  parameter int FRAME_HOLD_LOG2 = 7,
  parameter int VFP             = 6
) (
  input  logic            i_pclk,
  input  logic            i_arstn,
  dsi_pattern_gen_if.slave bus
);

  localparam int          BW     = MAX_HRES / 8;
  localparam logic [11:0] X_LAST = 12'(MAX_HRES / 2 - 1);
  localparam logic [11:0] Y_LAST = 12'(MAX_VRES - 1);
  localparam logic [15:0] VFP_C  = 16'(VFP);

  // Stage 1 registers. hs1_reg and vs1_reg also serve as the previous-value registers for edge detection.
  logic        hs1_reg, vs1_reg, de1_reg, valid1_reg;
  logic [11:0] x1_reg, y1_reg;
  logic [12:0] px_reg [2];

  logic        hs2_reg, vs2_reg, de2_reg, valid2_reg;
  logic [11:0] x2_reg, y2_reg;
  logic [47:0] data_reg;

  logic [2:0]  pattern_reg;
  logic [8:0]  frame_cnt_reg;
  logic [15:0] hs_cnt_reg;
  logic        video_rstn_reg;

  logic [23:0] colour [2];

  function automatic logic [2:0] bar_index(input logic [12:0] p);
    logic [2:0] k;
    k = 3'd0;
    for (int t = 1; t < 8; t++) begin
      if (p >= 13'(t * BW)) k = k + 3'd1;
    end
    return k;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] k);
    case (k)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pixel_colour(input logic [2:0] pat, input logic [12:0] p,
                                               input logic [7:0] y8);
    logic [7:0] ramp;
    ramp = p[7:0] + y8;
    case (pat)
      3'd0:    return {p[7:0], 16'h0000};
      3'd1:    return {8'h00, p[7:0], 8'h00};
      3'd2:    return {16'h0000, p[7:0]};
      3'd3:    return {ramp, ramp, ramp};
      3'd4:    return bar_colour(bar_index(p));
      3'd5:    return (p[5] ^ y8[5]) ? 24'hFFFFFF : 24'h000000;
      3'd6:    return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pix
      assign colour[gi] = pixel_colour(pattern_reg, px_reg[gi], y1_reg[7:0]);
    end
  endgenerate

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      hs1_reg    <= 1'b0;
      vs1_reg    <= 1'b0;
      de1_reg    <= 1'b0;
      valid1_reg <= 1'b0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      px_reg[0]  <= '0;
      px_reg[1]  <= '0;
      hs2_reg    <= 1'b0;
      vs2_reg    <= 1'b0;
      de2_reg    <= 1'b0;
      valid2_reg <= 1'b0;
      x2_reg     <= '0;
      y2_reg     <= '0;
      data_reg   <= '0;
    end else begin
      hs1_reg    <= bus.i_hs;
      vs1_reg    <= bus.i_vs;
      de1_reg    <= bus.i_de;
      valid1_reg <= bus.i_valid;
      x1_reg     <= bus.i_x;
      y1_reg     <= bus.i_y;
      px_reg[0]  <= {bus.i_x, 1'b0};
      px_reg[1]  <= {bus.i_x, 1'b1};
      hs2_reg    <= hs1_reg;
      vs2_reg    <= vs1_reg;
      de2_reg    <= de1_reg;
      valid2_reg <= valid1_reg;
      x2_reg     <= x1_reg;
      y2_reg     <= y1_reg;
      data_reg   <= (de1_reg && valid1_reg) ? {colour[1], colour[0]} : 48'd0;
    end
  end

  // The pattern latch reads frame_cnt_reg before the update in the same edge. As a result, a coincident vs rise and frame end latches the old count.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      pattern_reg    <= 3'd0;
      frame_cnt_reg  <= 9'd0;
      hs_cnt_reg     <= 16'd0;
      video_rstn_reg <= 1'b0;
    end else begin
      if (bus.i_vs && !vs1_reg)
        pattern_reg <= bus.i_mode_auto ? {1'b0, frame_cnt_reg[FRAME_HOLD_LOG2+1 -: 2]} : bus.i_mode;
      if (bus.i_valid && bus.i_y == Y_LAST && bus.i_x == X_LAST)
        frame_cnt_reg <= frame_cnt_reg + 9'd1;
      if (bus.i_hs && !hs1_reg && hs_cnt_reg != VFP_C)
        hs_cnt_reg <= hs_cnt_reg + 16'd1;
      if (hs_cnt_reg == VFP_C)
        video_rstn_reg <= 1'b1;
    end
  end

  assign bus.o_hs         = hs2_reg;
  assign bus.o_vs         = vs2_reg;
  assign bus.o_de         = de2_reg;
  assign bus.o_valid      = valid2_reg;
  assign bus.o_x          = x2_reg;
  assign bus.o_y          = y2_reg;
  assign bus.o_data       = data_reg;
  assign bus.o_frame_cnt  = frame_cnt_reg;
  assign bus.o_video_rstn = video_rstn_reg;

endmodule

// File: tb/tb_dsi_pattern_gen.sv
// Directed bench for dsi_pattern_gen. It runs with FRAME_HOLD_LOG2 = 0 so that auto mode steps the pattern on every frame.
// It drives the frame-end coordinates directly to exercise the frame counter.
module tb_dsi_pattern_gen;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fc_exp = 0;

  dsi_pattern_gen_if vif ();

  dsi_pattern_gen #(
    .MAX_HRES(1080), .MAX_VRES(1920), .FRAME_HOLD_LOG2(0), .VFP(6)
  ) dut (
    .i_pclk (clk),
    .i_arstn(arstn),
    .bus    (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vif.i_vs = 1'b1;
    tick();
    vif.i_vs = 1'b0;
    tick();
  endtask

  task automatic pixel(input string tag, input logic [11:0] x, input logic [11:0] y,
                       input logic [47:0] exp);
    vif.i_x = x; vif.i_y = y; vif.i_de = 1'b1; vif.i_valid = 1'b1;
    tick();
    vif.i_de = 1'b0; vif.i_valid = 1'b0;
    tick();
    check(tag, vif.o_data, exp);
  endtask

  task automatic frame_end(input int n);
    vif.i_x = 12'd539; vif.i_y = 12'd1919; vif.i_de = 1'b1; vif.i_valid = 1'b1;
    repeat (n) tick();
    vif.i_de = 1'b0; vif.i_valid = 1'b0;
    fc_exp = (fc_exp + n) % 512;
  endtask

  localparam logic [47:0] P0 = 48'h0B0000_0A0000;
  localparam logic [47:0] P1 = 48'h000B00_000A00;
  localparam logic [47:0] P2 = 48'h00000B_00000A;
  localparam logic [47:0] P3 = 48'h151515_141414;
  logic [47:0] auto_exp [5];

  initial begin
    auto_exp[0] = P0; auto_exp[1] = P1; auto_exp[2] = P2; auto_exp[3] = P3; auto_exp[4] = P0;
    vif.i_hs = 1'b0; vif.i_vs = 1'b0; vif.i_de = 1'b0; vif.i_valid = 1'b0;
    vif.i_x = '0; vif.i_y = '0; vif.i_mode = 3'd0; vif.i_mode_auto = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_data", vif.o_data, 48'd0);
    check("rst_de", 48'(vif.o_de), 48'd0);
    check("rst_fcnt", 48'(vif.o_frame_cnt), 48'd0);
    check("rst_rstn", 48'(vif.o_video_rstn), 48'd0);
    arstn = 1'b1;
    tick();

    // Reset release after the sixth hs rising edge
    for (int i = 0; i < 6; i++) begin
      vif.i_hs = 1'b1;
      tick();
      check($sformatf("rstn_hs%0d_hi", i + 1), 48'(vif.o_video_rstn), 48'd0);
      vif.i_hs = 1'b0;
      tick();
      check($sformatf("rstn_hs%0d_lo", i + 1), 48'(vif.o_video_rstn), (i == 5) ? 48'd1 : 48'd0);
    end

    // Manual patterns
    vif.i_mode = 3'd0; vs_pulse();
    pixel("mode0", 12'd5, 12'd10, P0);
    check("mode0_x", 48'(vif.o_x), 48'd5);
    check("mode0_y", 48'(vif.o_y), 48'd10);
    tick();
    check("mode0_de_low", vif.o_data, 48'd0);

    vif.i_mode = 3'd3; vs_pulse();
    pixel("mode3", 12'd200, 12'd100, 48'hF5F5F5_F4F4F4);

    vif.i_mode = 3'd4; vs_pulse();
    pixel("bars_134_135", 12'd67, 12'd0, 48'hFFFF00_FFFFFF);
    pixel("bars_1078_1079", 12'd539, 12'd0, 48'h000000_000000);
    pixel("bars_270_271", 12'd135, 12'd0, 48'h00FFFF_00FFFF);

    vif.i_mode = 3'd5; vs_pulse();
    pixel("check_x16_y32", 12'd16, 12'd32, 48'd0);
    pixel("check_x15_y32", 12'd15, 12'd32, 48'hFFFFFF_FFFFFF);

    vif.i_mode = 3'd7; vs_pulse();
    pixel("mode7", 12'd5, 12'd10, 48'd0);
    vif.i_mode = 3'd6; vs_pulse();
    pixel("mode6", 12'd5, 12'd10, 48'hFFFFFF_FFFFFF);

    // Mid-frame mode change only takes effect after the next vs rise
    vif.i_mode = 3'd0;
    pixel("latch_hold", 12'd5, 12'd10, 48'hFFFFFF_FFFFFF);
    vs_pulse();
    pixel("latch_new", 12'd5, 12'd10, P0);

    // Auto mode, one frame per pattern
    vif.i_mode = 3'd7; vif.i_mode_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vs_pulse();
      pixel($sformatf("auto_step%0d", i), 12'd5, 12'd10, auto_exp[i]);
      if (i < 4) frame_end(1);
    end
    check("auto_fcnt", 48'(vif.o_frame_cnt), 48'(fc_exp));

    // When the vs rise coincides with a frame end, the latch samples the old count (4, pattern 0)
    vif.i_vs = 1'b1;
    frame_end(1);
    vif.i_vs = 1'b0;
    tick();
    check("coinc_fcnt", 48'(vif.o_frame_cnt), 48'd5);
    pixel("coinc_pattern", 12'd5, 12'd10, P0);

    // Frame counter wrap
    frame_end(511 - fc_exp);
    check("fcnt_511", 48'(vif.o_frame_cnt), 48'd511);
    frame_end(1);
    check("fcnt_wrap", 48'(vif.o_frame_cnt), 48'd0);
    frame_end(3);
    check("fcnt_3", 48'(vif.o_frame_cnt), 48'(fc_exp));

    // Asynchronous reset asserted while active video is flowing
    vif.i_x = 12'd5; vif.i_y = 12'd10; vif.i_de = 1'b1; vif.i_valid = 1'b1;
    tick(); tick();
    check("pre_rst_de", 48'(vif.o_de), 48'd1);
    #2 arstn = 1'b0;
    #1;
    check("mid_rst_de", 48'(vif.o_de), 48'd0);
    check("mid_rst_data", vif.o_data, 48'd0);
    check("mid_rst_xy", 48'({vif.o_x, vif.o_y}), 48'd0);
    check("mid_rst_fcnt", 48'(vif.o_frame_cnt), 48'd0);
    check("mid_rst_rstn", 48'(vif.o_video_rstn), 48'd0);
    vif.i_de = 1'b0; vif.i_valid = 1'b0;
    tick();
    arstn = 1'b1;
    vif.i_hs = 1'b1; tick(); vif.i_hs = 1'b0; tick(); tick();
    check("post_rst_rstn", 48'(vif.o_video_rstn), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
